wb_arbiter: RTL and testbench

- Writeback-side initiator for the CPU register file.
- Merges results from the single-cycle ALU pipe and from the long-latency mul/div unit (MDU) into the register file's single write port (Rd, RegWrite, Wr_data).
- Buffers MDU results in a small FIFO and guarantees MDU progress with an anti-starvation counter.
- Keeps a pending-destination scoreboard that the decode stage uses for hazard stalls.

---
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered MDU results onto the single
// register-file write port, with MDU anti-starvation and a pending-write scoreboard.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy_mask,
    output logic        RegWrite,
    output logic [4:0]  Rd,
    output logic [31:0] Wr_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     wr_data_q, wr_data_d;

    logic            fifo_ne_c;
    logic            alu_req_c;
    logic            stall_c;
    logic            ready_c;
    logic            pop_c;
    logic            push_c;
    logic            alu_win_c;
    entry_t          head_c;

    assign fifo_ne_c = (count_q != '0);
    assign alu_req_c = alu_valid && (alu_rd != 5'd0);
    assign stall_c   = fifo_ne_c && (starve_q == SW'(STARVE_LIMIT));
    assign ready_c   = (count_q < CW'(DEPTH));
    assign pop_c     = fifo_ne_c && (stall_c || !alu_req_c);
    assign alu_win_c = alu_req_c && !stall_c;
    // rd=0 transfers complete the handshake but are dropped
    assign push_c    = mdu_valid && ready_c && (mdu_rd != 5'd0);
    assign head_c    = mem_q[rd_ptr_q];

    assign alu_stall = stall_c;
    assign mdu_ready = ready_c;
    assign busy_mask = busy_q;
    assign RegWrite  = reg_write_q;
    assign Rd        = rd_q;
    assign Wr_data   = wr_data_q;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        busy_d      = busy_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wr_data_d   = wr_data_q;

        if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_c || !fifo_ne_c) begin
            starve_d = '0;
        end else if (alu_win_c && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end

        if (pop_c) begin
            reg_write_d = 1'b1;
            rd_d        = head_c.rd;
            wr_data_d   = head_c.data;
        end else if (alu_win_c) begin
            reg_write_d = 1'b1;
            rd_d        = alu_rd;
            wr_data_d   = alu_data;
        end

        // clear before set so a same-cycle reissue keeps the bit
        if (pop_c) busy_d[head_c.rd] = 1'b0;
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            busy_q      <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wr_data_q   <= 32'd0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            busy_q      <= busy_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= '{rd: mdu_rd, data: mdu_data};
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter with hand-written sequences for
// full-FIFO push/pop collision and asynchronous reset mid-stream.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy_mask;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
        .RegWrite(RegWrite), .Rd(Rd), .Wr_data(Wr_data)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        iv;
        logic [4:0]  ird;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_stall;
        logic        e_rdy;
        logic [31:0] e_bm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adata,
                                logic mv, logic [4:0] mrd, logic [31:0] mdata,
                                logic iv, logic [4:0] ird,
                                logic rw, logic [4:0] rd, logic [31:0] wd,
                                logic st, logic rdy, logic [31:0] bm);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.mv = mv; v.mrd = mrd; v.mdata = mdata;
        v.iv = iv; v.ird = ird;
        v.e_rw = rw; v.e_rd = rd; v.e_wd = wd;
        v.e_stall = st; v.e_rdy = rdy; v.e_bm = bm;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive at posedge+1, let one edge pass, compare at the following posedge+1
    task automatic apply(string tag, vec_t v);
        alu_valid   = v.av;  alu_rd = v.ard; alu_data = v.adata;
        mdu_valid   = v.mv;  mdu_rd = v.mrd; mdu_data = v.mdata;
        issue_valid = v.iv;  issue_rd = v.ird;
        @(posedge clk);
        #1;
        check({tag, ".RegWrite"},  32'(RegWrite),  32'(v.e_rw));
        check({tag, ".Rd"},        32'(Rd),        32'(v.e_rd));
        check({tag, ".Wr_data"},   Wr_data,        v.e_wd);
        check({tag, ".alu_stall"}, 32'(alu_stall), 32'(v.e_stall));
        check({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(v.e_rdy));
        check({tag, ".busy_mask"}, busy_mask,      v.e_bm);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
    endtask

    localparam logic [31:0] AD = 32'h1111_0000;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.RegWrite",  32'(RegWrite),  32'd0);
        check("reset.Rd",        32'(Rd),        32'd0);
        check("reset.Wr_data",   Wr_data,        32'd0);
        check("reset.busy_mask", busy_mask,      32'd0);
        check("reset.alu_stall", 32'(alu_stall), 32'd0);
        check("reset.mdu_ready", 32'(mdu_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,1,0));

        // ALU path, rd=0 suppression, discarded MDU rd=0 transfer
        vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 1,5,32'hDEADBEEF, 0,1,0));
        vecs.push_back(mk(1,0,32'h12345678, 0,0,0, 0,0, 0,5,32'hDEADBEEF, 0,1,0));
        vecs.push_back(mk(0,0,0, 1,0,32'hC0FFEE00, 0,0, 0,5,32'hDEADBEEF, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,5,32'hDEADBEEF, 0,1,0));

        // scoreboard: set on issue, clear on writeback, reissue in pop cycle wins
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 0,5,32'hDEADBEEF, 0,1,32'h80));
        vecs.push_back(mk(0,0,0, 1,7,32'h77770001, 0,0, 0,5,32'hDEADBEEF, 0,1,32'h80));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,7,32'h77770001, 0,1,32'h0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 0,7,32'h77770001, 0,1,32'h80));
        vecs.push_back(mk(0,0,0, 1,7,32'h77770002, 0,0, 0,7,32'h77770001, 0,1,32'h80));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 1,7,32'h77770002, 0,1,32'h80));
        vecs.push_back(mk(0,0,0, 1,7,32'h77770003, 0,0, 0,7,32'h77770002, 0,1,32'h80));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,7,32'h77770003, 0,1,32'h0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 0,7,32'h77770003, 0,1,32'h0));

        // fill under constant ALU pressure, starvation stall, in-order drain
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk(1,20,AD, 1,5'(k),32'hC000_0000 + 32'(k), 0,0,
                              1,20,AD, 0,(k < 4),0));
        for (int k = 4; k <= 8; k++)
            vecs.push_back(mk(1,20,AD, 1,5,32'hC000_0005, 0,0, 1,20,AD, (k == 8),0,0));
        vecs.push_back(mk(1,20,AD, 1,5,32'hC000_0005, 0,0, 1,1,32'hC000_0001, 0,1,0));
        vecs.push_back(mk(0,0,0,   1,5,32'hC000_0005, 0,0, 1,2,32'hC000_0002, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,3,32'hC000_0003, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,4,32'hC000_0004, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 1,5,32'hC000_0005, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,5,32'hC000_0005, 0,1,0));

        @(posedge clk);
        #1;
        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // full FIFO: push offered in the pop cycle is refused, three entries remain
        for (int k = 0; k < 4; k++)
            apply($sformatf("full.fill%0d", k),
                  mk(1,20,AD, 1,5'(11 + k),32'hB000_0000 + 32'(11 + k), 0,0,
                     1,20,AD, 0,(k < 3),0));
        check("full.ready_before_pop", 32'(mdu_ready), 32'd0);
        apply("full.collide", mk(0,0,0, 1,15,32'hB000_000F, 0,0, 1,11,32'hB000_000B, 0,1,0));
        apply("full.drain12", mk(0,0,0, 0,0,0, 0,0, 1,12,32'hB000_000C, 0,1,0));
        apply("full.drain13", mk(0,0,0, 0,0,0, 0,0, 1,13,32'hB000_000D, 0,1,0));
        apply("full.drain14", mk(0,0,0, 0,0,0, 0,0, 1,14,32'hB000_000E, 0,1,0));
        apply("full.empty",   mk(0,0,0, 0,0,0, 0,0, 0,14,32'hB000_000E, 0,1,0));

        // async reset between edges with three entries queued
        apply("rst.issue", mk(0,0,0, 0,0,0, 1,3, 0,14,32'hB000_000E, 0,1,32'h8));
        for (int k = 0; k < 3; k++)
            apply($sformatf("rst.fill%0d", k),
                  mk(1,21,32'h2222_0000, 1,5'(1 + k),32'hD000_0000 + 32'(k), 0,0,
                     1,21,32'h2222_0000, 0,1,32'h8));
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("rst.async.RegWrite",  32'(RegWrite),  32'd0);
        check("rst.async.Rd",        32'(Rd),        32'd0);
        check("rst.async.Wr_data",   Wr_data,        32'd0);
        check("rst.async.busy_mask", busy_mask,      32'd0);
        check("rst.async.mdu_ready", 32'(mdu_ready), 32'd1);
        check("rst.async.alu_stall", 32'(alu_stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++)
            apply($sformatf("rst.after%0d", k), mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,1,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
